// File: rtl/inst_fetch_buffer.sv
// Decoupled instruction fetch front end: sequential SRAM fetch into a small
// PC/instruction FIFO consumed by ID, with branch redirect and delay-slot keep.
module inst_fetch_buffer #(
   parameter int                 DEPTH    = 4,
   parameter int                 ADDR_W   = 32,
   parameter int                 INST_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'hbfc00000)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       br_e,
   input  logic [ADDR_W-1:0]          br_addr,
   input  logic                       br_keep,
   input  logic                       id_ready,
   output logic                       out_valid,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [INST_W-1:0]          out_inst,
   output logic                       inst_sram_en,
   output logic [3:0]                 inst_sram_wen,
   output logic [ADDR_W-1:0]          inst_sram_addr,
   output logic [31:0]                inst_sram_wdata,
   input  logic [INST_W-1:0]          inst_sram_rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       dbg_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = CW + 1;

   typedef enum logic {RUN = 1'b0, SLOT = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [ADDR_W-1:0] iss_pc_q, iss_pc_d;
   logic              inflight_q, inflight_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];

   logic              slot_case;
   logic              push;
   logic              pop;
   logic              room;
   logic              issue;
   logic [OW-1:0]     occ;

   // Redirect with keep but nothing buffered or landing: the slot must still be fetched.
   assign slot_case = br_e && br_keep && (count_q == '0) && !inflight_q;
   assign pop       = (count_q != '0) && id_ready && !br_e;
   assign push      = br_e ? (br_keep && (count_q == '0) && inflight_q) : inflight_q;
   assign occ       = {1'b0, count_q} + OW'(inflight_q) + OW'(push);
   assign room      = occ < (OW'(DEPTH) + OW'(pop));
   assign issue     = rst && room && (!br_e || slot_case);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= RUN;
      else      state_q <= state_d;
   end

   // Next-state logic: SLOT lasts exactly one cycle, any redirect there returns to RUN
   always_comb begin
      state_d = RUN;
      if (slot_case) state_d = SLOT;
   end

   // Output logic
   always_comb begin
      inst_sram_en    = issue;
      inst_sram_addr  = (state_q == SLOT) ? pend_addr_q : fetch_pc_q;
      inst_sram_wen   = 4'b0000;
      inst_sram_wdata = 32'h0;
      dbg_state       = state_q;
   end

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      pend_addr_d = pend_addr_q;
      if (br_e) begin
         if (slot_case) begin
            fetch_pc_d  = fetch_pc_q + ADDR_W'(4);
            pend_addr_d = br_addr;
         end else begin
            fetch_pc_d  = br_addr;
         end
      end else if (state_q == SLOT) begin
         fetch_pc_d = issue ? pend_addr_q + ADDR_W'(4) : pend_addr_q;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      iss_pc_d   = issue ? inst_sram_addr : iss_pc_q;
      inflight_d = issue;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (br_e) begin
         if (br_keep && (count_q != '0)) begin
            wr_ptr_d = rd_ptr_q + PW'(1);
            count_d  = CW'(1);
         end else if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = CW'(1);
         end else begin
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
         end
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q  <= RESET_PC;
         pend_addr_q <= RESET_PC;
         iss_pc_q    <= RESET_PC;
         inflight_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         pend_addr_q <= pend_addr_d;
         iss_pc_q    <= iss_pc_d;
         inflight_q  <= inflight_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Entry storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= iss_pc_q;
         inst_mem_q[wr_ptr_q] <= inst_sram_rdata;
      end
   end

   assign out_valid = (count_q != '0);
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_inst  = inst_mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Decoupled instruction-fetch front end for the next-generation mycpu core; replaces direct IF-to-ID coupling.
- Issues sequential fetches to the synchronous inst SRAM (1-cycle read latency) and buffers returned instructions with their PCs in a DEPTH-entry FIFO; ID consumes entries through a valid/ready handshake.
- Accepts branch redirects from ID, with optional preservation of the MIPS delay-slot instruction.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >=2.
- ADDR_W, 32, PC / SRAM address width.
- INST_W, 32, instruction width.
- RESET_PC, 32'hbfc00000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- br_e  in  1  redirect request from ID, single-cycle pulse.
- br_addr  in  ADDR_W  redirect target.
- br_keep  in  1  with br_e: preserve the delay-slot instruction (next in program order after the branch).
- id_ready  in  1  ID accepts the head entry this cycle.
- out_valid  out  1  head entry valid.
- out_pc  out  ADDR_W  head PC.
- out_inst  out  INST_W  head instruction.
- inst_sram_en  out  1  fetch strobe.
- inst_sram_wen  out  4  constant 0.
- inst_sram_addr  out  ADDR_W  fetch address.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_rdata  in  INST_W  read data, valid the cycle after en.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, FIFO empty, count=0, out_valid=0, inst_sram_en=0, no in-flight fetch, state RUN.
- First cycle after deassertion: en=1, addr=RESET_PC.
- Issue rule: en=1 when count + inflight + push_this_cycle - pop_this_cycle < DEPTH, with no flush suppressing it.
  - addr = fetch_pc; fetch_pc += 4 on issue.
  - At most one issue per cycle; issues are pipelined back-to-back.
- Response: inflight registered from en. In cycle t+1 rdata is pushed together with the registered issue PC unless that response is marked dropped.
- Pop: out_valid && id_ready. Push and pop may occur in the same cycle; count is unchanged. Reads on an empty FIFO and writes to a full FIFO are impossible by the issue rule.
- Outputs: out_valid = (count != 0); out_pc and out_inst are driven from head storage; there is no same-cycle bypass, so the minimum issue-to-out_valid latency is 2 cycles.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is width-extended.
- Redirect, br_e=1 and br_keep=0:
  - Flush all entries, including any pop this cycle (ID must not pop with br_e).
  - Mark the in-flight response dropped.
  - fetch_pc = br_addr.
  - The issue in the same cycle is suppressed; the next cycle issues br_addr.
- Redirect, br_e=1 and br_keep=1; the oldest unconsumed instruction is the slot:
  - count >= 1: keep the head, flush the rest, drop in-flight; count=1; fetch_pc = br_addr.
  - count == 0, inflight=1: keep the in-flight response as the sole entry; fetch_pc = br_addr.
  - count == 0, inflight=0: enter SLOT. Issue fetch_pc (the slot), save br_addr in pend_addr. The next cycle sets fetch_pc = pend_addr and returns to RUN.
  - In SLOT, a new br_e overrides pend_addr and goes to RUN.
- Simultaneous events:
  - br_e has priority over push, pop and issue bookkeeping.
  - Any response landing in the redirect cycle obeys the keep rules above.
- Reset mid-operation: everything is discarded immediately; state returns to the reset values.
- fetch_pc wraps modulo 2^ADDR_W. Alignment is not checked (handled by the exception logic).

Test Plan:
- Reset release, id_ready=1 -> addrs bfc00000, bfc00004, ... one per cycle. out_valid first rises 2 cycles after the first en; out_pc sequence matches the addrs.
- id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 issues total, count=4, en=0. Set id_ready=1 -> pops 1/cycle, en resumes the next cycle, no PC gap or duplicate.
- count=3 (PCs bfc00010..18) plus one in flight, br_e=1, br_keep=0, br_addr=bfc00100 -> count=0, in-flight dropped; the next out_pc is bfc00100.
- Same setup with br_keep=1 -> only bfc00010 remains (count=1), then bfc00100, bfc00104, ...
- Empty FIFO, no in-flight, br_keep=1, fetch_pc=bfc00020, br_addr=bfc00200 -> issues bfc00020 then bfc00200. out_pc sequence: bfc00020, bfc00200.
- rst pulsed low mid-stream with count=2 -> out_valid=0 and count=0 asynchronously; refetch starts at bfc00000.
